// File: rtl/noise_detect_stream.sv
// Per-channel salt-and-pepper flagging on a valid/ready stream with a saturating per-frame count.
// Latency 1 beat; s_ready = !m_valid || m_ready, so the output register stalls in place under backpressure.
module noise_detect_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 3,
    parameter int T1_INIT    = 0,
    parameter int T2_INIT    = 255,
    parameter int CNT_WIDTH  = 20
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_we,
    input  logic [DATA_WIDTH-1:0]          cfg_t1,
    input  logic [DATA_WIDTH-1:0]          cfg_t2,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [CHANNELS*DATA_WIDTH-1:0] s_data,
    input  logic                           s_last,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [CHANNELS*DATA_WIDTH-1:0] m_data,
    output logic [CHANNELS-1:0]            m_noise,
    output logic                           m_last,
    output logic                           cnt_valid,
    output logic [CNT_WIDTH-1:0]           cnt_value,
    output logic                           cnt_sat
);
    localparam int PW = $clog2(CHANNELS + 1);
    localparam int SW = CNT_WIDTH + PW;
    localparam logic [SW-1:0] MAX_EXT = SW'({CNT_WIDTH{1'b1}});

    logic [DATA_WIDTH-1:0]          r_t1_sh, r_t2_sh, r_t1_act, r_t2_act;
    logic                           r_in_frame;
    logic [CNT_WIDTH-1:0]           r_acc;
    logic                           r_acc_sat;
    logic                           r_m_valid, r_m_last, r_cnt_valid, r_cnt_sat;
    logic [CHANNELS*DATA_WIDTH-1:0] r_m_data;
    logic [CHANNELS-1:0]            r_m_noise;
    logic [CNT_WIDTH-1:0]           r_cnt_value;

    logic [DATA_WIDTH-1:0] w_t1_eff, w_t2_eff;
    logic [CHANNELS-1:0]   w_flags;
    logic [PW-1:0]         w_pop;
    logic [SW-1:0]         w_sum;
    logic                  w_ovf;
    logic [CNT_WIDTH-1:0]  w_acc_next;
    logic                  w_accept;

    // Thresholds are latched into the active pair on every beat, so they only move at frame starts.
    assign w_t1_eff = r_in_frame ? r_t1_act : r_t1_sh;
    assign w_t2_eff = r_in_frame ? r_t2_act : r_t2_sh;

    always_comb begin
        w_flags = '0;
        w_pop   = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            w_flags[k] = (s_data[k*DATA_WIDTH +: DATA_WIDTH] <= w_t1_eff) ||
                         (s_data[k*DATA_WIDTH +: DATA_WIDTH] >= w_t2_eff);
            w_pop      = w_pop + PW'(w_flags[k]);
        end
    end

    assign w_sum      = {{PW{1'b0}}, r_acc} + SW'(w_pop);
    assign w_ovf      = w_sum > MAX_EXT;
    assign w_acc_next = w_ovf ? {CNT_WIDTH{1'b1}} : w_sum[CNT_WIDTH-1:0];

    assign s_ready  = !r_m_valid || m_ready;
    assign w_accept = s_valid && s_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_t1_sh     <= DATA_WIDTH'(T1_INIT);
            r_t2_sh     <= DATA_WIDTH'(T2_INIT);
            r_t1_act    <= DATA_WIDTH'(T1_INIT);
            r_t2_act    <= DATA_WIDTH'(T2_INIT);
            r_in_frame  <= 1'b0;
            r_acc       <= '0;
            r_acc_sat   <= 1'b0;
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
            r_m_noise   <= '0;
            r_m_last    <= 1'b0;
            r_cnt_valid <= 1'b0;
            r_cnt_value <= '0;
            r_cnt_sat   <= 1'b0;
        end else begin
            r_cnt_valid <= 1'b0;
            if (cfg_we) begin
                r_t1_sh <= cfg_t1;
                r_t2_sh <= cfg_t2;
            end
            if (w_accept) begin
                r_m_valid  <= 1'b1;
                r_m_data   <= s_data;
                r_m_noise  <= w_flags;
                r_m_last   <= s_last;
                r_t1_act   <= w_t1_eff;
                r_t2_act   <= w_t2_eff;
                r_in_frame <= !s_last;
                if (s_last) begin
                    r_cnt_valid <= 1'b1;
                    r_cnt_value <= w_acc_next;
                    r_cnt_sat   <= r_acc_sat || w_ovf;
                    r_acc       <= '0;
                    r_acc_sat   <= 1'b0;
                end else begin
                    r_acc       <= w_acc_next;
                    r_acc_sat   <= r_acc_sat || w_ovf;
                end
            end else if (m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign m_valid   = r_m_valid;
    assign m_data    = r_m_data;
    assign m_noise   = r_m_noise;
    assign m_last    = r_m_last;
    assign cnt_valid = r_cnt_valid;
    assign cnt_value = r_cnt_value;
    assign cnt_sat   = r_cnt_sat;
endmodule

// File: tb/tb_noise_detect_stream.sv
// Directed bench for noise_detect_stream: a default instance plus a CNT_WIDTH=3 instance sharing stimulus.
module tb_noise_detect_stream;
    logic        clk = 1'b0;
    logic        rst, cfg_we, s_valid, s_last, m_ready;
    logic [7:0]  cfg_t1, cfg_t2;
    logic [23:0] s_data;

    logic        s_ready, m_valid, m_last, cnt_valid, cnt_sat;
    logic [23:0] m_data;
    logic [2:0]  m_noise;
    logic [19:0] cnt_value;

    logic        s_ready3, m_valid3, m_last3, cnt_valid3, cnt_sat3;
    logic [23:0] m_data3;
    logic [2:0]  m_noise3;
    logic [2:0]  cnt_value3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    noise_detect_stream dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_t1(cfg_t1), .cfg_t2(cfg_t2),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_noise(m_noise),
        .m_last(m_last), .cnt_valid(cnt_valid), .cnt_value(cnt_value), .cnt_sat(cnt_sat)
    );

    noise_detect_stream #(.CNT_WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_t1(cfg_t1), .cfg_t2(cfg_t2),
        .s_valid(s_valid), .s_ready(s_ready3), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid3), .m_ready(m_ready), .m_data(m_data3), .m_noise(m_noise3),
        .m_last(m_last3), .cnt_valid(cnt_valid3), .cnt_value(cnt_value3), .cnt_sat(cnt_sat3)
    );

    function automatic logic [23:0] px(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
        return {c2, c1, c0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [23:0] d, input logic l);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        tick();
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_last  = 1'b0;
        tick();
    endtask

    task automatic cfg(input logic [7:0] t1, input logic [7:0] t2);
        cfg_we = 1'b1; cfg_t1 = t1; cfg_t2 = t2;
        s_valid = 1'b0; s_last = 1'b0;
        tick();
        cfg_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_t1 = 8'd0; cfg_t2 = 8'd0;
        s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b1;
        #1;
        tick(); tick();
        rst = 1'b0;

        // reset state
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_noise", m_noise, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_cnt_valid", cnt_valid, 0);
        chk("rst_cnt_value", cnt_value, 0);
        chk("rst_cnt_sat", cnt_sat, 0);
        chk("rst_s_ready", s_ready, 1);

        // basic 4-beat frame at default thresholds 0/255
        send(px(0, 128, 255), 1'b0);
        chk("f1b0_valid", m_valid, 1);
        chk("f1b0_data", m_data, px(0, 128, 255));
        chk("f1b0_noise", m_noise, 3'b101);
        chk("f1b0_last", m_last, 0);
        chk("f1b0_cntv", cnt_valid, 0);
        send(px(10, 20, 30), 1'b0);
        chk("f1b1_noise", m_noise, 3'b000);
        send(px(255, 255, 0), 1'b0);
        chk("f1b2_noise", m_noise, 3'b111);
        send(px(1, 2, 3), 1'b1);
        chk("f1b3_noise", m_noise, 3'b000);
        chk("f1b3_last", m_last, 1);
        chk("f1_cnt_valid", cnt_valid, 1);
        chk("f1_cnt_value", cnt_value, 5);
        chk("f1_cnt_sat", cnt_sat, 0);
        idle();
        chk("f1_cnt_pulse_end", cnt_valid, 0);
        chk("f1_cnt_hold", cnt_value, 5);
        chk("f1_m_valid_drop", m_valid, 0);

        // mid-frame threshold write takes effect on the next frame
        send(px(0, 0, 0), 1'b0);
        chk("thr_a_noise", m_noise, 3'b111);
        cfg(8'd10, 8'd200);
        send(px(10, 200, 11), 1'b0);
        chk("thr_b_noise_old", m_noise, 3'b000);
        send(px(255, 5, 100), 1'b1);
        chk("thr_c_noise_old", m_noise, 3'b001);
        chk("thr_f_cnt", cnt_value, 4);
        // first beat of next frame uses the new shadow; same-cycle write is deferred a frame
        cfg_we = 1'b1; cfg_t1 = 8'd50; cfg_t2 = 8'd60;
        send(px(10, 200, 11), 1'b1);
        cfg_we = 1'b0;
        chk("thr_new_noise", m_noise, 3'b011);
        chk("thr_new_cnt", cnt_value, 2);
        send(px(55, 50, 61), 1'b1);
        chk("thr_defer_noise", m_noise, 3'b110);
        cfg(8'd0, 8'd255);

        // backpressure
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = px(5, 6, 7); s_last = 1'b0;
        #1;
        chk("bp_ready_empty", s_ready, 1);
        tick();
        s_data = px(0, 9, 9);
        chk("bp_p1_data", m_data, px(5, 6, 7));
        chk("bp_ready_full", s_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_valid", m_valid, 1);
            chk("bp_hold_data", m_data, px(5, 6, 7));
            chk("bp_hold_noise", m_noise, 3'b000);
            chk("bp_hold_last", m_last, 0);
            chk("bp_hold_ready", s_ready, 0);
        end
        m_ready = 1'b1;
        #1;
        chk("bp_ready_release", s_ready, 1);
        tick();
        chk("bp_p2_data", m_data, px(0, 9, 9));
        chk("bp_p2_noise", m_noise, 3'b001);
        send(px(9, 255, 9), 1'b1);
        chk("bp_p3_data", m_data, px(9, 255, 9));
        chk("bp_p3_noise", m_noise, 3'b010);
        chk("bp_p3_last", m_last, 1);
        chk("bp_cnt", cnt_value, 2);
        idle();
        chk("bp_drain", m_valid, 0);

        // saturation on the 3-bit counter instance
        for (int i = 0; i < 4; i++) send(px(0, 0, 0), i == 3);
        chk("sat3_cnt_valid", cnt_valid3, 1);
        chk("sat3_cnt_value", cnt_value3, 7);
        chk("sat3_cnt_sat", cnt_sat3, 1);
        chk("sat20_cnt_value", cnt_value, 12);
        send(px(5, 5, 5), 1'b1);
        chk("sat3_clean_value", cnt_value3, 0);
        chk("sat3_clean_sat", cnt_sat3, 0);

        // reset mid-frame with non-default thresholds programmed
        cfg(8'd100, 8'd150);
        send(px(100, 1, 1), 1'b0);
        send(px(0, 0, 0), 1'b0);
        chk("mrst_pre_valid", m_valid, 1);
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0;
        tick();
        rst = 1'b0;
        chk("mrst_m_valid", m_valid, 0);
        chk("mrst_m_data", m_data, 0);
        chk("mrst_cnt_valid", cnt_valid, 0);
        idle();
        chk("mrst_no_pulse", cnt_valid, 0);
        send(px(0, 150, 5), 1'b1);
        chk("mrst_noise_defaults", m_noise, 3'b001);
        chk("mrst_cnt_valid_after", cnt_valid, 1);
        chk("mrst_cnt_from_zero", cnt_value, 1);

        // back-to-back single-beat frames
        for (int i = 0; i < 4; i++) begin
            send(px(0, 0, 0), 1'b1);
            chk("b2b_cnt_valid", cnt_valid, 1);
            chk("b2b_cnt_value", cnt_value, 3);
            chk("b2b_noise", m_noise, 3'b111);
        end
        idle();
        chk("b2b_end", cnt_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
